// File: rtl/audio_proc_pkg.sv
// Shared definitions for the audio frame processor: mode codes, FSM state
// encoding and the signed-range check used by the saturating datapath.
package audio_proc_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_GAIN   = 2'b01;
    localparam logic [1:0] MODE_MUTE   = 2'b10;
    localparam logic [1:0] MODE_INVERT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        PROC  = 2'b10,
        WRITE = 2'b11
    } state_e;

    // True when v does not fit in a w-bit two's complement value, i.e. the
    // result must be clamped to the w-bit max/min.
    function automatic logic sat_overflow(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -hi - longint'(1);
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/audio_sat_mul.sv
// Per-sample datapath shared by all channels: bypass, mute, saturating
// negate, or Q2 gain multiply with arithmetic shift and saturation.
module audio_sat_mul
    import audio_proc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned GAIN_W   = 16
) (
    input  logic [1:0]                 mode_i,
    input  logic signed [SAMPLE_W-1:0] x_i,
    input  logic [GAIN_W-1:0]          gain_i,
    output logic signed [SAMPLE_W-1:0] y_o,
    output logic                       clip_o
);

    localparam int unsigned PW    = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned SHIFT = GAIN_W - 2;
    localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic signed [PW-1:0]     x_ext;
    logic signed [PW-1:0]     g_ext;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;
    logic signed [SAMPLE_W:0] neg;
    logic                     scaled_ovf;
    logic                     neg_ovf;

    // Gain is unsigned, so it is zero-extended before the signed multiply;
    // >>> on the signed product rounds toward -inf.
    assign x_ext      = {{(GAIN_W+1){x_i[SAMPLE_W-1]}}, x_i};
    assign g_ext      = {{SAMPLE_W{1'b0}}, 1'b0, gain_i};
    assign prod       = x_ext * g_ext;
    assign scaled     = prod >>> SHIFT;
    assign neg        = -{x_i[SAMPLE_W-1], x_i};
    assign scaled_ovf = sat_overflow(longint'(scaled), SAMPLE_W);
    assign neg_ovf    = sat_overflow(longint'(neg), SAMPLE_W);

    // Select the per-mode result and flag any clamping.
    always_comb begin
        y_o    = '0;
        clip_o = 1'b0;
        case (mode_i)
            MODE_BYPASS: y_o = x_i;
            MODE_MUTE:   y_o = '0;
            MODE_INVERT: begin
                if (neg_ovf) begin
                    y_o    = SAT_MAX;
                    clip_o = 1'b1;
                end else begin
                    y_o = neg[SAMPLE_W-1:0];
                end
            end
            MODE_GAIN: begin
                if (scaled_ovf) begin
                    y_o    = scaled[PW-1] ? SAT_MIN : SAT_MAX;
                    clip_o = 1'b1;
                end else begin
                    y_o = scaled[SAMPLE_W-1:0];
                end
            end
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/audio_stream_proc.sv
// Frame processor between the ADC (receive) FIFO and DAC (transmit) FIFO.
// One frame at a time: read, process each channel through a shared
// datapath, then write once the DAC FIFO has room.
// Optional feature macro: AUDIO_PROC_PEAK_EN adds the peak/peak_clr ports.
module audio_stream_proc
    import audio_proc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned GAIN_W   = 16,
    localparam int unsigned FRAME_W = CHANNELS * SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 mode,
    input  logic [CHANNELS*GAIN_W-1:0] gain,
    input  logic                       adcfifo_empty,
    output logic                       adcfifo_read,
    input  logic [FRAME_W-1:0]         adcfifo_readdata,
    input  logic                       dacfifo_full,
    output logic                       dacfifo_write,
    output logic [FRAME_W-1:0]         dacfifo_writedata,
    output logic [CHANNELS-1:0]        clip,
    input  logic                       clip_clr,
    output logic [31:0]                frame_count,
`ifdef AUDIO_PROC_PEAK_EN
    output logic [FRAME_W-1:0]         peak,
    input  logic                       peak_clr,
`endif
    output logic                       busy
);

    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_e                     state_q;
    logic [1:0]                 mode_q;
    logic [CHANNELS*GAIN_W-1:0] gain_q;
    logic [FRAME_W-1:0]         frame_q;
    logic [FRAME_W-1:0]         wdata_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       read_q;
    logic                       write_q;
    logic                       busy_q;
    logic [31:0]                count_q;
    logic [CHANNELS-1:0]        clip_q;
    logic [CHANNELS-1:0]        clip_d;

    logic signed [SAMPLE_W-1:0] x_sel;
    logic [GAIN_W-1:0]          g_sel;
    logic signed [SAMPLE_W-1:0] y;
    logic                       y_clip;

    // Route the current channel's sample and gain into the shared datapath.
    always_comb begin
        x_sel = '0;
        g_sel = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (idx_q == IDX_W'(c)) begin
                x_sel = frame_q[c*SAMPLE_W +: SAMPLE_W];
                g_sel = gain_q[c*GAIN_W +: GAIN_W];
            end
        end
    end

    audio_sat_mul #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W)
    ) u_sat_mul (
        .mode_i (mode_q),
        .x_i    (x_sel),
        .gain_i (g_sel),
        .y_o    (y),
        .clip_o (y_clip)
    );

    // Frame FSM with registered strobes, shadowed mode/gain and output frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_BYPASS;
            gain_q  <= '0;
            frame_q <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!adcfifo_empty) begin
                        read_q  <= 1'b1;
                        mode_q  <= mode;
                        gain_q  <= gain;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    frame_q <= adcfifo_readdata;
                    idx_q   <= '0;
                    state_q <= PROC;
                end
                PROC: begin
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        if (idx_q == IDX_W'(c)) begin
                            wdata_q[c*SAMPLE_W +: SAMPLE_W] <= y;
                        end
                    end
                    if (idx_q == IDX_W'(CHANNELS - 1)) begin
                        state_q <= WRITE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (!dacfifo_full) begin
                        write_q <= 1'b1;
                        count_q <= count_q + 32'd1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky clip flags: a set in the same cycle as clip_clr takes priority.
    always_comb begin
        clip_d = clip_clr ? '0 : clip_q;
        if (state_q == PROC && y_clip) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (idx_q == IDX_W'(c)) begin
                    clip_d[c] = 1'b1;
                end
            end
        end
    end

    // Clip flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

`ifdef AUDIO_PROC_PEAK_EN
    localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [FRAME_W-1:0] peak_q;
    logic [FRAME_W-1:0] peak_d;

    // Peak magnitude update on the edge that issues the DAC write; the
    // clear is applied first so a coincident update leaves the new |y|.
    always_comb begin : peak_next
        logic [SAMPLE_W-1:0] smp;
        logic [SAMPLE_W-1:0] mag;
        smp    = '0;
        mag    = '0;
        peak_d = peak_clr ? '0 : peak_q;
        if (state_q == WRITE && !dacfifo_full) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                smp = wdata_q[c*SAMPLE_W +: SAMPLE_W];
                if (!smp[SAMPLE_W-1]) begin
                    mag = smp;
                end else if (smp == SAT_MIN) begin
                    mag = SAT_MAX;
                end else begin
                    mag = -smp;
                end
                if (mag > peak_d[c*SAMPLE_W +: SAMPLE_W]) begin
                    peak_d[c*SAMPLE_W +: SAMPLE_W] = mag;
                end
            end
        end
    end

    // Peak register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

    assign adcfifo_read      = read_q;
    assign dacfifo_write     = write_q;
    assign dacfifo_writedata = wdata_q;
    assign clip              = clip_q;
    assign frame_count       = count_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_audio_stream_proc.sv
// Directed bench for audio_stream_proc with default parameters
// (16-bit samples, 2 channels, 16-bit gain). Covers peak ports when
// AUDIO_PROC_PEAK_EN is defined.
module tb_audio_stream_proc;
    import audio_proc_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mode;
    logic [31:0] gain;
    logic        adcfifo_empty;
    logic        adcfifo_read;
    logic [31:0] adcfifo_readdata;
    logic        dacfifo_full;
    logic        dacfifo_write;
    logic [31:0] dacfifo_writedata;
    logic [1:0]  clip;
    logic        clip_clr;
    logic [31:0] frame_count;
    logic        busy;
`ifdef AUDIO_PROC_PEAK_EN
    logic [31:0] peak;
    logic        peak_clr;
`endif

    int n_vec = 0;
    int n_err = 0;

    audio_stream_proc #(
        .SAMPLE_W (16),
        .CHANNELS (2),
        .GAIN_W   (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mode              (mode),
        .gain              (gain),
        .adcfifo_empty     (adcfifo_empty),
        .adcfifo_read      (adcfifo_read),
        .adcfifo_readdata  (adcfifo_readdata),
        .dacfifo_full      (dacfifo_full),
        .dacfifo_write     (dacfifo_write),
        .dacfifo_writedata (dacfifo_writedata),
        .clip              (clip),
        .clip_clr          (clip_clr),
        .frame_count       (frame_count),
`ifdef AUDIO_PROC_PEAK_EN
        .peak              (peak),
        .peak_clr          (peak_clr),
`endif
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one frame from the ADC FIFO and watch 12 cycles of handshakes.
    task automatic run_frame(input logic [31:0] din, input logic [1:0] m, input logic [31:0] g,
                             output logic [31:0] dout, output int rd_cyc, output int wr_cyc,
                             output int n_rd, output int n_wr);
        @(negedge clk);
        mode             = m;
        gain             = g;
        adcfifo_readdata = din;
        adcfifo_empty    = 1'b0;
        dout   = '0;
        rd_cyc = -1;
        wr_cyc = -1;
        n_rd   = 0;
        n_wr   = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (adcfifo_read) begin
                n_rd++;
                if (rd_cyc < 0) rd_cyc = i;
                adcfifo_empty = 1'b1;
            end
            if (dacfifo_write) begin
                n_wr++;
                if (wr_cyc < 0) wr_cyc = i;
                dout = dacfifo_writedata;
            end
        end
    endtask

    task automatic do_frame(input string tag, input logic [31:0] din, input logic [1:0] m,
                            input logic [31:0] g, input logic [31:0] exp);
        logic [31:0] dout;
        int rd_cyc, wr_cyc, n_rd, n_wr;
        run_frame(din, m, g, dout, rd_cyc, wr_cyc, n_rd, n_wr);
        check({tag, ".data"},    dout, exp);
        check({tag, ".reads"},   n_rd, 1);
        check({tag, ".writes"},  n_wr, 1);
        check({tag, ".latency"}, wr_cyc - rd_cyc, 4);
    endtask

    task automatic pulse_clip_clr();
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dout;
        int  n_rd, n_wr;
        logic stable;

        reset_n          = 1'b0;
        mode             = MODE_BYPASS;
        gain             = '0;
        adcfifo_empty    = 1'b1;
        adcfifo_readdata = '0;
        dacfifo_full     = 1'b0;
        clip_clr         = 1'b0;
`ifdef AUDIO_PROC_PEAK_EN
        peak_clr         = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst.read",  adcfifo_read, 0);
        check("rst.write", dacfifo_write, 0);
        check("rst.wdata", dacfifo_writedata, 0);
        check("rst.clip",  clip, 0);
        check("rst.count", frame_count, 0);
        check("rst.busy",  busy, 0);
        reset_n = 1'b1;

        do_frame("bypass", 32'h8001_7FFF, MODE_BYPASS, 32'h0, 32'h8001_7FFF);
        check("bypass.count", frame_count, 1);
        check("bypass.clip",  clip, 0);
        check("bypass.busy",  busy, 0);

        do_frame("gain_a", 32'h5000_3000, MODE_GAIN, 32'h4000_8000, 32'h5000_6000);
        check("gain_a.clip", clip, 2'b00);
        do_frame("gain_b", 32'h1000_5000, MODE_GAIN, 32'h4000_8000, 32'h1000_7FFF);
        check("gain_b.clip", clip, 2'b01);
        pulse_clip_clr();
        check("clip_clr", clip, 2'b00);

        do_frame("gain_neg", 32'hB000_C000, MODE_GAIN, 32'h8000_8000, 32'h8000_8000);
        check("gain_neg.clip", clip, 2'b10);
        pulse_clip_clr();
        do_frame("gain_half", 32'h0000_FFFF, MODE_GAIN, 32'h2000_2000, 32'h0000_FFFF);
        check("gain_half.clip", clip, 2'b00);

        do_frame("invert", 32'h8000_0001, MODE_INVERT, 32'h0, 32'h7FFF_FFFF);
        check("invert.clip", clip, 2'b10);
        do_frame("mute", 32'h1234_5678, MODE_MUTE, 32'h0, 32'h0000_0000);
        check("mute.clip",  clip, 2'b10);
        check("mute.count", frame_count, 7);

        // Back-pressure: DAC full across the WRITE state, FIFO still non-empty.
        @(negedge clk);
        dacfifo_full     = 1'b1;
        mode             = MODE_BYPASS;
        gain             = '0;
        adcfifo_readdata = 32'h1234_5678;
        adcfifo_empty    = 1'b0;
        n_rd   = 0;
        n_wr   = 0;
        stable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (adcfifo_read)  n_rd++;
            if (dacfifo_write) n_wr++;
            if (i >= 4 && dacfifo_writedata !== 32'h1234_5678) stable = 1'b0;
            if (i == 8) mode = MODE_INVERT;
        end
        check("bp.stall_writes", n_wr, 0);
        check("bp.stall_reads",  n_rd, 1);
        check("bp.stable",       stable, 1);
        dacfifo_full = 1'b0;
        @(negedge clk);
        check("bp.write",       dacfifo_write, 1);
        check("bp.wdata",       dacfifo_writedata, 32'h1234_5678);
        check("bp.no_read",     adcfifo_read, 0);
        check("bp.count",       frame_count, 8);
        @(negedge clk);
        check("bp.next_read",   adcfifo_read, 1);
        check("bp.write_once",  dacfifo_write, 0);
        adcfifo_empty = 1'b1;
        n_wr = 0;
        dout = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dacfifo_write) begin
                n_wr++;
                dout = dacfifo_writedata;
            end
        end
        check("bp2.writes", n_wr, 1);
        check("bp2.data",   dout, 32'hEDCC_A988);
        check("bp2.count",  frame_count, 9);

        // Asynchronous reset while the frame is in PROC.
        @(negedge clk);
        mode             = MODE_BYPASS;
        adcfifo_readdata = 32'h1111_2222;
        adcfifo_empty    = 1'b0;
        @(negedge clk);
        adcfifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        check("mid.busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst.read",  adcfifo_read, 0);
        check("mid_rst.write", dacfifo_write, 0);
        check("mid_rst.wdata", dacfifo_writedata, 0);
        check("mid_rst.clip",  clip, 0);
        check("mid_rst.count", frame_count, 0);
        check("mid_rst.busy",  busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_frame("post_rst", 32'h0100_F000, MODE_BYPASS, 32'h0, 32'h0100_F000);
        check("post_rst.count", frame_count, 1);
`ifdef AUDIO_PROC_PEAK_EN
        check("peak.first", peak, 32'h0100_1000);
`endif
        do_frame("post_rst2", 32'h0050_0200, MODE_BYPASS, 32'h0, 32'h0050_0200);
        check("post_rst2.count", frame_count, 2);
`ifdef AUDIO_PROC_PEAK_EN
        check("peak.hold", peak, 32'h0100_1000);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak.clr", peak, 32'h0);
        do_frame("peak_min", 32'h8000_0003, MODE_BYPASS, 32'h0, 32'h8000_0003);
        check("peak.min", peak, 32'h7FFF_0003);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
